// File: rtl/line_write_buffer.sv
// rtl/line_write_buffer.sv - line-granularity write-back buffer between a cache memory port and main_mem
// Dirty lines are absorbed into a small FIFO and drained in the background; reads hit the FIFO or fetch.
module line_write_buffer #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int DEPTH         = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic                                 gnt,
    input  logic [ADDR_LEN-1:0]                  addr,
    input  logic                                 rd_req,
    output logic [32*(1<<LINE_ADDR_LEN)-1:0]     rd_line,
    input  logic                                 wr_req,
    input  logic [32*(1<<LINE_ADDR_LEN)-1:0]     wr_line,
    input  logic                                 mem_gnt,
    output logic [ADDR_LEN-1:0]                  mem_addr,
    output logic                                 mem_rd_req,
    input  logic [32*(1<<LINE_ADDR_LEN)-1:0]     mem_rd_line,
    output logic                                 mem_wr_req,
    output logic [32*(1<<LINE_ADDR_LEN)-1:0]     mem_wr_line,
    output logic [$clog2(DEPTH):0]               wb_count
);

    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int LINE_W    = 32 * LINE_SIZE;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, FETCH, RESP} state_t;

    state_t                 state_q, state_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [ADDR_LEN-1:0]    ent_addr_q [DEPTH];
    logic [ADDR_LEN-1:0]    ent_addr_d [DEPTH];
    logic [LINE_W-1:0]      ent_data_q [DEPTH];
    logic [LINE_W-1:0]      ent_data_d [DEPTH];
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   gnt_q, gnt_d;
    logic [LINE_W-1:0]      rd_line_q, rd_line_d;
    logic                   fetch_pend_q, fetch_pend_d;
    logic [ADDR_LEN-1:0]    fetch_addr_q, fetch_addr_d;
    logic                   mem_rd_req_q, mem_rd_req_d;
    logic                   mem_wr_req_q, mem_wr_req_d;
    logic [ADDR_LEN-1:0]    mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]      mem_wr_line_q, mem_wr_line_d;

    logic                   hit;
    logic [PTR_W-1:0]       hit_idx;
    logic                   up_idle, full, push, pop, coal_head;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && ent_addr_q[i] == addr) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    // Upstream is ignored during the grant cycle and while a fetch is outstanding.
    assign up_idle = !gnt_q && !fetch_pend_q;
    assign full    = (count_q == CNT_W'(DEPTH));

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        ent_addr_d    = ent_addr_q;
        ent_data_d    = ent_data_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        gnt_d         = 1'b0;
        rd_line_d     = rd_line_q;
        fetch_pend_d  = fetch_pend_q;
        fetch_addr_d  = fetch_addr_q;
        mem_rd_req_d  = mem_rd_req_q;
        mem_wr_req_d  = mem_wr_req_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_line_d = mem_wr_line_q;
        push          = 1'b0;
        pop           = 1'b0;
        coal_head     = 1'b0;

        if (up_idle && rd_req) begin
            if (hit) begin
                rd_line_d = ent_data_q[hit_idx];
                gnt_d     = 1'b1;
            end else begin
                fetch_pend_d = 1'b1;
                fetch_addr_d = addr;
            end
        end else if (up_idle && wr_req) begin
            if (hit) begin
                // The head being drained has already been handed to main_mem; leave it alone.
                if (!(state_q == DRAIN && hit_idx == head_q)) begin
                    ent_data_d[hit_idx] = wr_line;
                    gnt_d               = 1'b1;
                    coal_head           = (hit_idx == head_q);
                end
            end else if (!full) begin
                valid_d[tail_q]    = 1'b1;
                ent_addr_d[tail_q] = addr;
                ent_data_d[tail_q] = wr_line;
                tail_d             = tail_q + PTR_W'(1);
                gnt_d              = 1'b1;
                push               = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (fetch_pend_q) begin
                    state_d      = FETCH;
                    mem_rd_req_d = 1'b1;
                    mem_addr_d   = fetch_addr_q;
                end else if (count_q != '0) begin
                    state_d       = DRAIN;
                    mem_wr_req_d  = 1'b1;
                    mem_addr_d    = ent_addr_q[head_q];
                    // A same-cycle coalesce into the head must reach main_mem.
                    mem_wr_line_d = coal_head ? wr_line : ent_data_q[head_q];
                end
            end
            DRAIN: begin
                if (mem_gnt) begin
                    state_d         = IDLE;
                    mem_wr_req_d    = 1'b0;
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + PTR_W'(1);
                    pop             = 1'b1;
                end
            end
            FETCH: begin
                if (mem_gnt) begin
                    state_d      = RESP;
                    mem_rd_req_d = 1'b0;
                    rd_line_d    = mem_rd_line;
                    gnt_d        = 1'b1;
                end
            end
            RESP: begin
                state_d      = IDLE;
                fetch_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            gnt_q         <= 1'b0;
            rd_line_q     <= '0;
            fetch_pend_q  <= 1'b0;
            fetch_addr_q  <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_wr_req_q  <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_line_q <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            ent_addr_q    <= ent_addr_d;
            ent_data_q    <= ent_data_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            gnt_q         <= gnt_d;
            rd_line_q     <= rd_line_d;
            fetch_pend_q  <= fetch_pend_d;
            fetch_addr_q  <= fetch_addr_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_wr_req_q  <= mem_wr_req_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_line_q <= mem_wr_line_d;
        end
    end

    assign gnt         = gnt_q;
    assign rd_line     = rd_line_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd_req  = mem_rd_req_q;
    assign mem_wr_req  = mem_wr_req_q;
    assign mem_wr_line = mem_wr_line_q;
    assign wb_count    = count_q;

endmodule

// File: tb/tb_line_write_buffer.sv
// tb/tb_line_write_buffer.sv - scoreboard bench for line_write_buffer
module tb_line_write_buffer;

    typedef logic [255:0] line_t;
    typedef struct packed {
        logic [8:0] a;
        line_t      d;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        gnt;
    logic [8:0]  addr;
    logic        rd_req;
    line_t       rd_line;
    logic        wr_req;
    line_t       wr_line;
    logic        mem_gnt;
    logic [8:0]  mem_addr;
    logic        mem_rd_req;
    line_t       mem_rd_line;
    logic        mem_wr_req;
    line_t       mem_wr_line;
    logic [2:0]  wb_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc_no = 0;
    bit saw_mem_rd;
    line_t exp_rd_q[$];
    wr_t   exp_wr_q[$];

    line_write_buffer #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .gnt(gnt), .addr(addr), .rd_req(rd_req),
        .rd_line(rd_line), .wr_req(wr_req), .wr_line(wr_line),
        .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
        .mem_rd_line(mem_rd_line), .mem_wr_req(mem_wr_req),
        .mem_wr_line(mem_wr_line), .wb_count(wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic line_t mk_line(input logic [31:0] base);
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    // Holds a request until gnt, keeps it through the gnt cycle, then drops it.
    task automatic do_req(input bit rd, input bit wr, input logic [8:0] a, input line_t l,
                          output int lat, output bit gnt_after);
        addr = a; wr_line = l; rd_req = rd; wr_req = wr; lat = 0;
        while (gnt !== 1'b1 && lat < 200) begin
            cyc();
            lat++;
            if (mem_rd_req) saw_mem_rd = 1'b1;
        end
        cyc();
        gnt_after = gnt;
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic serve_drain(output bit found, output logic [8:0] a, output line_t d, output int mg);
        int n = 0;
        while (mem_wr_req !== 1'b1 && n < 50) begin cyc(); n++; end
        found = mem_wr_req; a = mem_addr; d = mem_wr_line; mg = cyc_no;
        if (found) begin
            mem_gnt = 1'b1;
            cyc();
            mem_gnt = 1'b0;
        end
    endtask

    task automatic serve_fetch(input line_t resp, output bit found, output logic [8:0] a,
                               output bit gnt_at, output line_t rl);
        int n = 0;
        while (mem_rd_req !== 1'b1 && n < 50) begin cyc(); n++; end
        found = mem_rd_req; a = mem_addr; gnt_at = 1'b0; rl = '0;
        if (found) begin
            mem_rd_line = resp; mem_gnt = 1'b1;
            cyc();
            gnt_at = gnt; rl = rd_line;
            mem_gnt = 1'b0; mem_rd_line = '0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; addr = '0; rd_req = 0; wr_req = 0; wr_line = '0; mem_gnt = 0; mem_rd_line = '0;
        cyc(); cyc();
        rst = 1'b0;
        vectors++; if (gnt !== 1'b0) begin miscompares++; $display("FAIL reset_gnt got %b exp 0", gnt); end
        vectors++; if (wb_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", wb_count); end
        vectors++; if (mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin miscompares++; $display("FAIL reset_memreq got %b%b exp 00", mem_rd_req, mem_wr_req); end
        vectors++; if (mem_addr !== 9'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        vectors++; if (rd_line !== '0 || mem_wr_line !== '0) begin miscompares++; $display("FAIL reset_lines got %h / %h exp 0", rd_line, mem_wr_line); end
    endtask

    task automatic test_write_drain();
        int lat, mg; bit ga, found; logic [8:0] da; line_t dd; wr_t e;
        do_req(0, 1, 9'h012, mk_line(32'h100), lat, ga);
        exp_wr_q.push_back('{a: 9'h012, d: mk_line(32'h100)});
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL wr_latency got %0d exp 1", lat); end
        vectors++; if (ga !== 1'b0) begin miscompares++; $display("FAIL wr_gnt_width got %b exp 0", ga); end
        vectors++; if (wb_count !== 3'd1) begin miscompares++; $display("FAIL wr_count got %0d exp 1", wb_count); end
        serve_drain(found, da, dd, mg);
        e = exp_wr_q.pop_front();
        vectors++; if (found !== 1'b1 || da !== e.a) begin miscompares++; $display("FAIL drain_addr got %b/%h exp 1/%h", found, da, e.a); end
        vectors++; if (dd !== e.d) begin miscompares++; $display("FAIL drain_data got %h exp %h", dd, e.d); end
        vectors++; if (wb_count !== 3'd0 || mem_wr_req !== 1'b0) begin miscompares++; $display("FAIL drain_done got %0d/%b exp 0/0", wb_count, mem_wr_req); end
    endtask

    task automatic test_read_hit();
        int lat, mg; bit ga, found; logic [8:0] da; line_t dd; wr_t e;
        do_req(0, 1, 9'h012, mk_line(32'h100), lat, ga);
        exp_wr_q.push_back('{a: 9'h012, d: mk_line(32'h100)});
        saw_mem_rd = 1'b0;
        exp_rd_q.push_back(mk_line(32'h100));
        do_req(1, 0, 9'h012, '0, lat, ga);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL hit_latency got %0d exp 1", lat); end
        vectors++; if (rd_line !== exp_rd_q[0]) begin miscompares++; $display("FAIL hit_data got %h exp %h", rd_line, exp_rd_q[0]); end
        void'(exp_rd_q.pop_front());
        vectors++; if (saw_mem_rd !== 1'b0) begin miscompares++; $display("FAIL hit_no_fetch got %b exp 0", saw_mem_rd); end
        serve_drain(found, da, dd, mg);
        e = exp_wr_q.pop_front();
        vectors++; if (found !== 1'b1 || da !== e.a || dd !== e.d) begin miscompares++; $display("FAIL hit_drain got %h %h exp %h %h", da, dd, e.a, e.d); end
    endtask

    task automatic test_read_miss();
        int lat; bit ga, found, gnt_at, extra; logic [8:0] fa; line_t rl;
        exp_rd_q.push_back(mk_line(32'hA0));
        fork
            do_req(1, 0, 9'h055, '0, lat, ga);
            serve_fetch(mk_line(32'hA0), found, fa, gnt_at, rl);
        join
        vectors++; if (found !== 1'b1 || fa !== 9'h055) begin miscompares++; $display("FAIL miss_fetch_addr got %b/%h exp 1/055", found, fa); end
        vectors++; if (gnt_at !== 1'b1) begin miscompares++; $display("FAIL miss_gnt_timing got %b exp 1", gnt_at); end
        vectors++; if (rl !== exp_rd_q[0]) begin miscompares++; $display("FAIL miss_data got %h exp %h", rl, exp_rd_q[0]); end
        void'(exp_rd_q.pop_front());
        vectors++; if (ga !== 1'b0) begin miscompares++; $display("FAIL miss_gnt_width got %b exp 0", ga); end
        extra = 1'b0;
        for (int k = 0; k < 5; k++) begin cyc(); if (gnt || mem_rd_req) extra = 1'b1; end
        vectors++; if (extra !== 1'b0) begin miscompares++; $display("FAIL miss_reserved got %b exp 0", extra); end
    endtask

    task automatic test_full_stall();
        int lat, s, mg; bit ga, found, early; logic [8:0] da; line_t dd; wr_t e;
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1, 9'h020 + 9'(i * 16), mk_line(32'h200 + 32'(i) * 32'h100), lat, ga);
            exp_wr_q.push_back('{a: 9'h020 + 9'(i * 16), d: mk_line(32'h200 + 32'(i) * 32'h100)});
            vectors++; if (lat !== 1) begin miscompares++; $display("FAIL fill_latency_%0d got %0d exp 1", i, lat); end
        end
        vectors++; if (wb_count !== 3'd4) begin miscompares++; $display("FAIL fill_count got %0d exp 4", wb_count); end
        s = 0; mg = 0; early = 1'b0;
        fork
            begin s = cyc_no; do_req(0, 1, 9'h1F0, mk_line(32'h1F00), lat, ga); end
            begin
                for (int k = 0; k < 6; k++) begin cyc(); if (gnt) early = 1'b1; end
                serve_drain(found, da, dd, mg);
            end
        join
        e = exp_wr_q.pop_front();
        exp_wr_q.push_back('{a: 9'h1F0, d: mk_line(32'h1F00)});
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL full_stall got gnt %b exp 0", early); end
        vectors++; if (found !== 1'b1 || da !== e.a || dd !== e.d) begin miscompares++; $display("FAIL full_drain got %h %h exp %h %h", da, dd, e.a, e.d); end
        vectors++; if (s + lat !== mg + 2) begin miscompares++; $display("FAIL full_accept_cycle got %0d exp %0d", s + lat, mg + 2); end
        vectors++; if (wb_count !== 3'd4) begin miscompares++; $display("FAIL full_refill_count got %0d exp 4", wb_count); end
    endtask

    task automatic test_coalesce_full();
        int lat, mg; bit ga, found; logic [8:0] da; line_t dd; wr_t e;
        do_req(0, 1, 9'h040, mk_line(32'h900), lat, ga);
        foreach (exp_wr_q[i]) if (exp_wr_q[i].a == 9'h040) exp_wr_q[i].d = mk_line(32'h900);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL coal_latency got %0d exp 1", lat); end
        vectors++; if (wb_count !== 3'd4) begin miscompares++; $display("FAIL coal_count got %0d exp 4", wb_count); end
        for (int i = 0; i < 4; i++) begin
            serve_drain(found, da, dd, mg);
            e = exp_wr_q.pop_front();
            vectors++; if (found !== 1'b1 || da !== e.a || dd !== e.d) begin miscompares++; $display("FAIL coal_drain_%0d got %h %h exp %h %h", i, da, dd, e.a, e.d); end
        end
        vectors++; if (wb_count !== 3'd0) begin miscompares++; $display("FAIL coal_empty got %0d exp 0", wb_count); end
    endtask

    task automatic test_reset_mid_drain();
        int lat, n; bit ga, found, gnt_at; logic [8:0] fa; line_t rl;
        do_req(0, 1, 9'h0AB, mk_line(32'hC00), lat, ga);
        n = 0;
        while (mem_wr_req !== 1'b1 && n < 50) begin cyc(); n++; end
        vectors++; if (mem_wr_req !== 1'b1) begin miscompares++; $display("FAIL rst_pre_drain got %b exp 1", mem_wr_req); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_wr_q.delete();
        vectors++; if (mem_wr_req !== 1'b0 || wb_count !== 3'd0 || gnt !== 1'b0) begin miscompares++; $display("FAIL rst_mid_drain got %b/%0d/%b exp 0/0/0", mem_wr_req, wb_count, gnt); end
        exp_rd_q.push_back(mk_line(32'hD00));
        fork
            do_req(1, 0, 9'h0AB, '0, lat, ga);
            serve_fetch(mk_line(32'hD00), found, fa, gnt_at, rl);
        join
        vectors++; if (found !== 1'b1 || fa !== 9'h0AB) begin miscompares++; $display("FAIL rst_lost_fetch got %b/%h exp 1/0ab", found, fa); end
        vectors++; if (gnt_at !== 1'b1 || rl !== exp_rd_q[0]) begin miscompares++; $display("FAIL rst_lost_data got %b %h exp 1 %h", gnt_at, rl, exp_rd_q[0]); end
        void'(exp_rd_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_write_drain();
        test_read_hit();
        test_read_miss();
        test_full_stall();
        test_coalesce_full();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
